// File: rtl/instr_mem_loader_pkg.sv
// Shared types and default geometry for the instruction memory, its loader,
// and the fetch stage.
package instr_mem_loader_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_e;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Streaming program-load channel: the start request, the valid/ready word
// stream, and the loader's status back to the host.
interface instr_mem_loader_if
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic [ADDR_W:0]   load_count;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              load_busy;
  logic              load_done;
  logic              load_err;
  logic [DATA_W-1:0] load_csum;

  modport master (
    output load_start, load_base, load_count, load_valid, load_data,
    input  load_ready, load_busy, load_done, load_err, load_csum
  );

  modport slave (
    input  load_start, load_base, load_count, load_valid, load_data,
    output load_ready, load_busy, load_done, load_err, load_csum
  );

endinterface

// File: rtl/instr_mem_array.sv
// Instruction storage: one synchronous write port and two combinational read
// ports. Contents are deliberately not reset.
module instr_mem_array
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory with fetch/debug read ports, a legacy single-word write
// port, and a burst program loader that stalls the core while active.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  instr_mem_loader_if.slave lif
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  load_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Next-state, write-port arbitration and checksum update.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    csum_d    = csum_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;

    unique case (state_q)
      ST_IDLE: begin
        mem_we = wr_en;
        if (lif.load_start) begin
          csum_d = '0;
          err_d  = 1'b0;
          if (lif.load_count != '0) begin
            state_d = ST_LOAD;
            ptr_d   = lif.load_base;
            rem_d   = lif.load_count;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        if (lif.load_valid) begin
          mem_we    = 1'b1;
          mem_waddr = ptr_q;
          mem_wdata = lif.load_data;
          csum_d    = csum_q ^ lif.load_data;
          ptr_d     = ptr_q + ADDR_W'(1);
          rem_d     = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end else if (ptr_q == '1) begin
            // Top address written; the burst would wrap, so stop and flag it.
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_LOAD);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      csum_q  <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      csum_q  <= csum_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign lif.load_ready = ready_q;
  assign lif.load_busy  = busy_q;
  assign lif.load_done  = done_q;
  assign lif.load_err   = err_q;
  assign lif.load_csum  = csum_q;

  instr_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata),
    .raddr_a (fetch_addr),
    .rdata_a (fetch_data),
    .raddr_b (dbg_addr),
    .rdata_b (dbg_data)
  );

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Parametrised instruction memory with a combinational fetch port, an independent combinational debug read port, and a legacy single-word write port. Adds a streaming program loader: a valid/ready burst writer with auto-incrementing address, word count, overflow detection and XOR checksum. Sits between the CPU fetch stage and the host/UART program-download path. While a load is in progress it asserts a stall to the core.

Parameters:
DATA_W, 16, instruction word width in bits
ADDR_W, 8, address width; memory depth = 2**ADDR_W words

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
fetch_addr  in  ADDR_W  core fetch address
fetch_data  out  DATA_W  mem[fetch_addr], combinational
dbg_addr  in  ADDR_W  debug/display read address
dbg_data  out  DATA_W  mem[dbg_addr], combinational
wr_en  in  1  legacy single-word write strobe
wr_addr  in  ADDR_W  legacy write address
wr_data  in  DATA_W  legacy write data
load_start  in  1  one-cycle request to begin a burst load
load_base  in  ADDR_W  first address of the burst, sampled on accepted start
load_count  in  ADDR_W+1  number of words to load (0..2**ADDR_W), sampled on accepted start
load_valid  in  1  source has a word on load_data
load_data  in  DATA_W  burst word
load_ready  out  1  block accepts load_data this cycle
load_busy  out  1  loader not IDLE; core must stall fetch
load_done  out  1  one-cycle pulse when burst ends
load_err  out  1  sticky overflow flag; cleared on next accepted start or reset
load_csum  out  DATA_W  XOR of all words written by current/last burst

Behaviour:
- Reset: state IDLE; load_ready=0, load_busy=0, load_done=0, load_err=0, load_csum=0, internal pointer/remaining=0. Memory array is NOT cleared; contents survive reset. Reset mid-burst aborts immediately; words already written stay written, no done pulse.
- Reads: fetch_data/dbg_data are pure combinational array reads; a write committed at edge N is visible on both ports after edge N. Same-cycle read of an address being written returns the old word.
- States: IDLE, LOAD, DONE.
- IDLE: load_start=1 and load_count!=0 -> LOAD; ptr<=load_base, remaining<=load_count, load_csum<=0, load_err<=0. load_start=1 with load_count=0 -> DONE, load_csum<=0, load_err<=0, no write. Legacy write: wr_en=1 writes mem[wr_addr]<=wr_data at edge.
- LOAD: load_ready=1, load_busy=1. On load_valid&&load_ready: mem[ptr]<=load_data, load_csum<=load_csum^load_data, ptr<=ptr+1, remaining<=remaining-1. If remaining==1 -> DONE. Else if ptr==2**ADDR_W-1 (next word would wrap) -> load_err<=1, DONE; the word at the top address is written, remaining words are not accepted. No valid -> hold, no timeout.
- DONE: one cycle; load_done=1, load_ready=0, load_busy=1; -> IDLE.
- wr_en is ignored (no write) in LOAD and DONE; load_start is ignored outside IDLE.
- Simultaneous wr_en and load_start in IDLE: legacy write commits, start is accepted the same edge.
- load_count=2**ADDR_W with load_base=0 fills the whole array with no error.
- Latency: first word can be accepted the cycle after start; one word per cycle sustained; load_done follows the last accepted word by one cycle.

Decomposition:
- Shared package: loader state enum (IDLE/LOAD/DONE) and DATA_W/ADDR_W defaults shared with the data memory and fetch stage.
- One natural sub-module: instr_mem_array (2**ADDR_W x DATA_W, one write port, two combinational read ports). Loader FSM, arbitration and checksum live in the top level.

Test Plan:
- Reset with pre-loaded mem[5]=16'hBEEF -> outputs all 0, fetch_addr=5 still reads 16'hBEEF.
- Start base=8'h10, count=4, stream 16'h1111,16'h2222,16'h4444,16'h8888 back-to-back -> mem[10..13] written, load_done one cycle after the 4th word, load_csum=16'hFFFF, load_err=0.
- Start base=8'hFE, count=4 -> words at FE and FF written, load_err=1, load_done pulse, mem[00] unchanged, load_ready low afterwards.
- Burst with load_valid gaps, plus wr_en to 8'h20 during LOAD -> mem[20] unchanged, burst words land correctly, load_busy high throughout.
- count=0 start -> DONE next cycle, load_done pulse, no writes, csum=0; then reset asserted mid-burst after 2 of 5 words -> IDLE, first 2 words retained, no done pulse.
- Legacy wr_en to 8'h07 with data 16'hA5A5 and fetch_addr=7 in the same cycle -> old data that cycle, 16'hA5A5 after the edge on both fetch and dbg ports.
